// File: rtl/axis_packetizer.sv
// ---------------------------------------------------------------------------------------------
// axis_packetizer
//
// Cuts an unframed AXI-Stream sample stream (no tlast on the input) into packets of a
// runtime-configurable length by generating tlast. Packet boundaries are honoured strictly:
// a packet that has started is always completed, and the configured length is only sampled
// when a new packet begins. While disabled, the input is drained (accepted and discarded) so
// the source never stalls.
//
// The output side is a 2-entry skid buffer driven straight from registers. s_axis_tready is
// itself a flop computed from next-state values, so there is no combinational path from
// m_axis_tready to s_axis_tready.
//
// Ports:
//   axis_aclk, axis_aresetn   clock, asynchronous active-low reset
//   cfg_enable                1 = produce packets, 0 = finish current packet then drain
//   cfg_packet_len            packet length in beats (0 -> 1, > MAX_PACKET_LEN -> MAX)
//   s_axis_*                  unframed input stream (tready/tdata/tvalid)
//   m_axis_*                  framed output stream (tready/tdata/tvalid/tlast)
//   sts_packet_count          complete packets handed off on the m side (wraps)
//   sts_busy                  packetizing, or beats still queued for the m side
// ---------------------------------------------------------------------------------------------
module axis_packetizer #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned MAX_PACKET_LEN   = 1024,
    parameter int unsigned LEN_W            = $clog2(MAX_PACKET_LEN) + 1
) (
    input  logic                        axis_aclk,
    input  logic                        axis_aresetn,

    input  logic                        cfg_enable,
    input  logic [LEN_W-1:0]            cfg_packet_len,

    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,

    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,

    output logic [31:0]                 sts_packet_count,
    output logic                        sts_busy
);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // Legal length range is 1..MAX_PACKET_LEN.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0) begin
            return LEN_W'(1);
        end else if (len > LEN_W'(MAX_PACKET_LEN)) begin
            return LEN_W'(MAX_PACKET_LEN);
        end else begin
            return len;
        end
    endfunction

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    state_e                      state_q;
    logic [LEN_W-1:0]            remaining_q;   // beats left in the packet after the next one

    logic [AXIS_TDATA_WIDTH-1:0] head_data_q;
    logic                        head_last_q;
    logic                        head_valid_q;
    logic [AXIS_TDATA_WIDTH-1:0] tail_data_q;
    logic                        tail_last_q;
    logic                        tail_valid_q;

    logic                        s_ready_q;
    logic                        busy_q;
    logic [31:0]                 pkt_cnt_q;

    // -----------------------------------------------------------------------------------------
    // Next-state helpers
    // -----------------------------------------------------------------------------------------
    logic             in_acc;
    logic             push;
    logic             pop;
    logic             beat_last;
    logic             run_start;
    logic             run_end;
    logic             run_next;
    logic [LEN_W-1:0] reload_len;
    logic             head_valid_d;
    logic             tail_valid_d;
    logic             push_to_head;
    logic             push_to_tail;

    assign in_acc     = s_axis_tvalid & s_axis_tready;
    // Beats accepted in IDLE (including the enabling cycle) are discarded.
    assign push       = in_acc & (state_q == StRun);
    assign pop        = head_valid_q & m_axis_tready;
    assign beat_last  = (remaining_q == '0);
    assign reload_len = clamp_len(cfg_packet_len) - LEN_W'(1);

    assign run_start  = (state_q == StIdle) & cfg_enable;
    assign run_end    = push & beat_last & ~cfg_enable;
    assign run_next   = run_start | ((state_q == StRun) & ~run_end);

    // Skid buffer occupancy after this edge. A pop frees the head (the tail moves up if
    // present); a push then lands in the first free slot, keeping FIFO order.
    always_comb begin
        head_valid_d = head_valid_q;
        tail_valid_d = tail_valid_q;
        push_to_head = 1'b0;
        push_to_tail = 1'b0;

        if (pop) begin
            if (tail_valid_q) begin
                tail_valid_d = 1'b0;
            end else begin
                head_valid_d = 1'b0;
            end
        end

        if (push) begin
            if (head_valid_d) begin
                push_to_tail = 1'b1;
                tail_valid_d = 1'b1;
            end else begin
                push_to_head = 1'b1;
                head_valid_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // FSM, skid buffer and status registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            head_data_q  <= '0;
            head_last_q  <= 1'b0;
            head_valid_q <= 1'b0;
            tail_data_q  <= '0;
            tail_last_q  <= 1'b0;
            tail_valid_q <= 1'b0;
            s_ready_q    <= 1'b1;
            busy_q       <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cfg_enable) begin
                        state_q     <= StRun;
                        remaining_q <= reload_len;
                    end
                end
                StRun: begin
                    if (push) begin
                        if (!beat_last) begin
                            remaining_q <= remaining_q - LEN_W'(1);
                        end else if (cfg_enable) begin
                            // Only point where a new length is picked up mid-stream.
                            remaining_q <= reload_len;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (push_to_head) begin
                head_data_q <= s_axis_tdata;
                head_last_q <= beat_last;
            end else if (pop && tail_valid_q) begin
                head_data_q <= tail_data_q;
                head_last_q <= tail_last_q;
            end

            if (push_to_tail) begin
                tail_data_q <= s_axis_tdata;
                tail_last_q <= beat_last;
            end

            head_valid_q <= head_valid_d;
            tail_valid_q <= tail_valid_d;

            // IDLE always drains; RUN accepts only while a slot will be free.
            s_ready_q <= ~run_next | ~tail_valid_d;
            busy_q    <= run_next | head_valid_d;

            if (pop && head_last_q) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign s_axis_tready    = s_ready_q;
    assign m_axis_tdata     = head_data_q;
    assign m_axis_tvalid    = head_valid_q;
    assign m_axis_tlast     = head_last_q;
    assign sts_packet_count = pkt_cnt_q;
    assign sts_busy         = busy_q;

endmodule

// File: tb/tb_axis_packetizer.sv
// ---------------------------------------------------------------------------------------------
// tb_axis_packetizer
//
// Directed bench for axis_packetizer. Inputs are driven 1 time unit after the rising edge;
// a negedge monitor records every m-side transfer into a queue and watches stall stability
// and buffer occupancy. Expected values are hand-computed in the stimulus below.
// ---------------------------------------------------------------------------------------------
module tb_axis_packetizer;

    localparam int DW   = 32;
    localparam int MAXL = 1024;
    localparam int LW   = 11;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cfg_enable;
    logic [LW-1:0] cfg_len;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic [31:0]   pkt_count;
    logic          busy;

    logic m_ready_fixed;
    logic bp_rand;
    logic rnd_bit = 1'b1;
    logic track;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign m_tready = bp_rand ? rnd_bit : m_ready_fixed;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    axis_packetizer #(
        .AXIS_TDATA_WIDTH(DW),
        .MAX_PACKET_LEN  (MAXL)
    ) dut (
        .axis_aclk       (clk),
        .axis_aresetn    (rstn),
        .cfg_enable      (cfg_enable),
        .cfg_packet_len  (cfg_len),
        .s_axis_tready   (s_tready),
        .s_axis_tdata    (s_tdata),
        .s_axis_tvalid   (s_tvalid),
        .m_axis_tready   (m_tready),
        .m_axis_tdata    (m_data),
        .m_axis_tvalid   (m_valid),
        .m_axis_tlast    (m_last),
        .sts_packet_count(pkt_count),
        .sts_busy        (busy)
    );

    // Monitor: transfers, stall stability, beats held inside the DUT.
    logic [32:0] obs_q[$];
    int          stall_err = 0;
    int          out_now   = 0;
    int          max_out   = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat  = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_valid || ({m_last, m_data} !== prev_beat))) begin
                stall_err++;
            end
            if (m_valid && m_tready) begin
                obs_q.push_back({m_last, m_data});
            end
            if (track) begin
                out_now = out_now + int'(s_tvalid && s_tready) - int'(m_valid && m_tready);
                if (out_now > max_out) begin
                    max_out = out_now;
                end
            end
            prev_stall = m_valid && !m_tready;
            prev_beat  = {m_last, m_data};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        bit done = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (s_tready) begin
                done = 1'b1;
            end
            tick();
        end
        s_tvalid = 1'b0;
        check("accept", 64'(done), 64'(1));
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 3000 && obs_q.size() < n; i++) begin
            tick();
        end
        tick();
    endtask

    task automatic do_reset();
        s_tvalid   = 1'b0;
        cfg_enable = 1'b0;
        rstn       = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        obs_q.delete();
        stall_err = 0;
        out_now   = 0;
        max_out   = 0;
    endtask

    initial begin
        int   bad;
        int   lasts;
        logic exp_last;

        rstn          = 1'b0;
        cfg_enable    = 1'b0;
        cfg_len       = LW'(4);
        s_tvalid      = 1'b0;
        s_tdata       = '0;
        m_ready_fixed = 1'b1;
        bp_rand       = 1'b0;
        track         = 1'b0;

        // Reset state
        #12;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_last", 64'(m_last), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_count", 64'(pkt_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_s_ready", 64'(s_tready), 64'(1));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        obs_q.delete();

        // Basic framing: len=4, data 0..11
        cfg_len    = LW'(4);
        cfg_enable = 1'b1;
        tick();
        check("t1_s_ready", 64'(s_tready), 64'(1));
        s_tdata  = 32'd0;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check("t1_lat_valid", 64'(m_valid), 64'(1));
        check("t1_lat_data", 64'(m_data), 64'(0));
        check("t1_lat_last", 64'(m_last), 64'(0));
        for (int i = 1; i < 12; i++) begin
            send_beat(32'(i));
        end
        wait_out(12);
        check("t1_size", 64'(obs_q.size()), 64'(12));
        for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
            exp_last = ((i % 4) == 3);
            check($sformatf("t1_beat%0d", i), 64'(obs_q[i]), 64'({exp_last, 32'(i)}));
        end
        check("t1_count", 64'(pkt_count), 64'(3));

        // Backpressure: len=3, random m_tready, 30 beats
        do_reset();
        cfg_len    = LW'(3);
        cfg_enable = 1'b1;
        tick();
        track   = 1'b1;
        bp_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send_beat(32'(100 + i));
        end
        wait_out(30);
        bp_rand = 1'b0;
        track   = 1'b0;
        tick();
        check("t2_size", 64'(obs_q.size()), 64'(30));
        bad = 0;
        for (int i = 0; i < 30 && i < obs_q.size(); i++) begin
            exp_last = ((i % 3) == 2);
            if (obs_q[i] !== {exp_last, 32'(100 + i)}) begin
                bad++;
            end
        end
        check("t2_seq_bad", 64'(bad), 64'(0));
        check("t2_stall_err", 64'(stall_err), 64'(0));
        check("t2_max_buf_le2", 64'(max_out <= 2), 64'(1));
        check("t2_count", 64'(pkt_count), 64'(10));

        // Length change and clamp
        do_reset();
        cfg_len    = LW'(2);
        cfg_enable = 1'b1;
        tick();
        send_beat(32'd200);
        cfg_len = LW'(5);
        send_beat(32'd201);
        for (int i = 202; i < 206; i++) begin
            send_beat(32'(i));
        end
        cfg_len = LW'(0);
        send_beat(32'd206);
        send_beat(32'd207);
        cfg_len = LW'(2000);
        send_beat(32'd208);
        for (int i = 0; i < 1024; i++) begin
            send_beat(32'h1000 + 32'(i));
        end
        wait_out(9 + 1024);
        check("t3_size", 64'(obs_q.size()), 64'(9 + 1024));
        for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
            exp_last = (i == 1) || (i == 6) || (i == 7) || (i == 8);
            check($sformatf("t3_beat%0d", i), 64'(obs_q[i]), 64'({exp_last, 32'(200 + i)}));
        end
        bad   = 0;
        lasts = 0;
        for (int i = 0; i < 1024 && (9 + i) < obs_q.size(); i++) begin
            if (obs_q[9 + i][31:0] !== 32'h1000 + 32'(i)) begin
                bad++;
            end
            if (obs_q[9 + i][32] === 1'b1) begin
                lasts++;
            end
        end
        check("t3_big_data_bad", 64'(bad), 64'(0));
        check("t3_big_last_cnt", 64'(lasts), 64'(1));
        if (obs_q.size() >= 9 + 1024) begin
            check("t3_big_final_last", 64'(obs_q[9 + 1023][32]), 64'(1));
        end
        check("t3_count", 64'(pkt_count), 64'(5));

        // Disable mid-packet: len=8, enable drops after beat 3
        do_reset();
        cfg_len    = LW'(8);
        cfg_enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            send_beat(32'(300 + i));
        end
        cfg_enable = 1'b0;
        for (int i = 4; i < 8; i++) begin
            send_beat(32'(300 + i));
        end
        check("t4_tail_valid", 64'(m_valid), 64'(1));
        check("t4_tail_data", 64'(m_data), 64'(307));
        check("t4_tail_last", 64'(m_last), 64'(1));
        check("t4_busy_flush", 64'(busy), 64'(1));
        tick();
        check("t4_valid_after", 64'(m_valid), 64'(0));
        check("t4_busy_after", 64'(busy), 64'(0));
        check("t4_drain_ready", 64'(s_tready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            send_beat(32'(400 + i));
        end
        tick();
        check("t4_drain_valid", 64'(m_valid), 64'(0));
        check("t4_size", 64'(obs_q.size()), 64'(8));
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            exp_last = (i == 7);
            check($sformatf("t4_beat%0d", i), 64'(obs_q[i]), 64'({exp_last, 32'(300 + i)}));
        end
        check("t4_count", 64'(pkt_count), 64'(1));

        // Enable edge: 0xAA in the enabling cycle is discarded
        do_reset();
        cfg_len    = LW'(2);
        s_tdata    = 32'hAA;
        s_tvalid   = 1'b1;
        cfg_enable = 1'b1;
        tick();
        s_tvalid = 1'b0;
        tick();
        check("t5_aa_dropped", 64'(m_valid), 64'(0));
        send_beat(32'hB0);
        send_beat(32'hB1);
        send_beat(32'hB2);
        cfg_len = LW'(4);
        send_beat(32'hB3);
        wait_out(4);
        check("t5_size", 64'(obs_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            exp_last = ((i % 2) == 1);
            check($sformatf("t5_beat%0d", i), 64'(obs_q[i]), 64'({exp_last, 32'hB0 + 32'(i)}));
        end
        check("t5_count", 64'(pkt_count), 64'(2));

        // Async reset after 2 of 4 beats (length 4 was loaded at the last boundary)
        send_beat(32'h50);
        send_beat(32'h51);
        check("t6_pre_valid", 64'(m_valid), 64'(1));
        check("t6_pre_data", 64'(m_data), 64'(32'h51));
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_valid", 64'(m_valid), 64'(0));
        check("t6_rst_count", 64'(pkt_count), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        obs_q.delete();
        tick();
        for (int i = 0; i < 4; i++) begin
            send_beat(32'h60 + 32'(i));
        end
        wait_out(4);
        check("t6_size", 64'(obs_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            exp_last = (i == 3);
            check($sformatf("t6_beat%0d", i), 64'(obs_q[i]), 64'({exp_last, 32'h60 + 32'(i)}));
        end
        check("t6_count", 64'(pkt_count), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_packetizer.md
Name: axis_packetizer

Overview:
Upstream framing stage for the AXI-Stream packet chain. It takes an unframed sample stream from an ADC or DSP source, which has no tlast, and cuts it into packets of a runtime-configurable length by generating tlast. Packets start and stop only on boundaries. While disabled, input is drained without stalling the source. Output is fully registered through a 2-entry skid buffer, so a full-throughput chain sees no combinational path from m_axis_tready to s_axis_tready.

Parameters:
AXIS_TDATA_WIDTH, 32, data width in bits.
MAX_PACKET_LEN, 1024, largest legal packet length in beats; must be >= 1.
LEN_W, $clog2(MAX_PACKET_LEN)+1, width of the length config port (derived; do not override).

Ports:
axis_aclk  in  1  clock.
axis_aresetn  in  1  asynchronous active-low reset.
cfg_enable  in  1  1 = produce packets; 0 = finish the current packet, then drain input.
cfg_packet_len  in  LEN_W  packet length in beats; sampled only at packet start.
s_axis_tready  out  1  input ready.
s_axis_tdata  in  AXIS_TDATA_WIDTH  input data.
s_axis_tvalid  in  1  input valid.
m_axis_tready  in  1  output ready.
m_axis_tdata  out  AXIS_TDATA_WIDTH  output data.
m_axis_tvalid  out  1  output valid.
m_axis_tlast  out  1  last beat of packet.
sts_packet_count  out  32  number of complete packets handed off on the m side.
sts_busy  out  1  1 while in RUN or while the skid buffer is non-empty.

Behaviour:
- Reset is axis_aresetn, asynchronous, active-low; clock is axis_aclk.
- Reset values: state=IDLE, skid buffer empty, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, sts_packet_count=0, sts_busy=0, remaining=0.
- Input acceptance: in_acc = s_axis_tvalid & s_axis_tready. Output transfer: out_acc = m_axis_tvalid & m_axis_tready.
- State IDLE:
  - s_axis_tready=1 and accepted beats are discarded.
  - If cfg_enable=1 at a clock edge: latch len = clamp(cfg_packet_len), set remaining=len-1, go to RUN.
  - The beat accepted in that same cycle is still discarded.
- Clamp rule: 0 becomes 1; values > MAX_PACKET_LEN become MAX_PACKET_LEN.
- State RUN:
  - s_axis_tready = skid buffer not full. This signal is registered, with no combinational dependence on m_axis_tready.
  - Each in_acc pushes {tdata, tlast=(remaining==0)} into the skid buffer.
  - Non-last beat: remaining decrements.
  - Last beat with cfg_enable=1: reload remaining = clamp(cfg_packet_len)-1 and stay in RUN. A new length takes effect only here.
  - Last beat with cfg_enable=0: go to IDLE.
  - cfg_enable falling mid-packet has no effect until the tlast beat is accepted; no partial packets are ever emitted.
- Length 1: every accepted beat carries tlast.
- Skid buffer: 2 entries, FIFO order.
  - Output is driven from the head register.
  - Latency: 1 cycle from in_acc to m_axis_tvalid when the buffer is empty.
  - Simultaneous push and pop keeps the occupancy unchanged.
  - Sustains 1 beat/cycle while m_axis_tready=1.
  - Data on the m side is held stable while m_axis_tvalid=1 and m_axis_tready=0.
  - IDLE drain never touches the buffer; queued beats still flush to m.
- sts_packet_count increments on out_acc & m_axis_tlast and wraps modulo 2^32.
- sts_busy = (state==RUN) | buffer non-empty.
- Reset mid-packet: the partial packet is lost; m_axis_tvalid drops immediately (asynchronously); after release the block restarts in IDLE.

Test Plan:
- Basic framing: len=4, enable=1, 12 consecutive beats (data 0..11), m_axis_tready=1 → tlast on data 3, 7, 11; sts_packet_count=3; first output valid 1 cycle after the first RUN acceptance.
- Backpressure: len=3, random m_axis_tready at 50%, 30 beats → output sequence identical to input, tlast every 3rd beat, no beat lost or duplicated, data stable while stalled, never more than 2 beats buffered.
- Length change and clamp: enable with len=2, change to len=5 mid-packet → current packet ends after 2 beats, next packet has 5 beats. len=0 → packets of 1 beat. len=2000 (MAX_PACKET_LEN=1024) → packets of 1024 beats.
- Disable mid-packet: len=8, drop cfg_enable after beat 3 → beats 4..7 still forwarded with tlast on beat 7; later input is discarded with s_axis_tready=1 and m_axis_tvalid=0; sts_busy falls after the last transfer.
- Enable edge: raise cfg_enable in a cycle with s_axis_tvalid=1 (data 0xAA) → 0xAA discarded; the first output packet starts with the next beat.
- Async reset mid-packet: assert axis_aresetn=0 after 2 of 4 beats → m_axis_tvalid=0 without waiting for a clock edge and sts_packet_count=0; after release with enable=1, a clean 4-beat packet follows.
